// File: rtl/serial_signed_sub_sat.sv
// serial_signed_sub_sat: bit-serial two's-complement subtractor (a - b) with
// saturation. The operands go LSB-first through one full adder and a carry
// flop, using a + ~b + 1, and the result is then clamped to the signed range.
// Optional feature macro: SUB_SAT_FLAG_EN adds a registered 'sat' output that
// flags a clamped result.
module serial_signed_sub_sat #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff
`ifdef SUB_SAT_FLAG_EN
  ,
  output logic             sat
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             sign_a;
  logic             sign_b;

  logic             sum_c;
  logic             carry_c;
  logic [WIDTH-1:0] r_next_c;
  logic             ovf_c;
  logic [WIDTH-1:0] sat_val_c;

  // One-bit full adder built from gates, plus the shifted result and the
  // overflow check on the final sign bit.
  always_comb begin
    sum_c     = a_sh[0] ^ b_sh[0] ^ carry;
    carry_c   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    r_next_c  = {sum_c, r_sh[WIDTH-1:1]};
    ovf_c     = (sign_a ^ sign_b) & (r_next_c[WIDTH-1] ^ sign_a);
    sat_val_c = sign_a ? MIN_NEG : MAX_POS;
  end

  // Control FSM and serial datapath; all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
`ifdef SUB_SAT_FLAG_EN
      sat       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= ~b;
            carry    <= 1'b1;
            cnt      <= '0;
            sign_a   <= a[WIDTH-1];
            sign_b   <= b[WIDTH-1];
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          carry <= carry_c;
          r_sh  <= r_next_c;
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          cnt   <= CNT_W'(cnt + 1'b1);
          if (cnt == LAST_BIT) begin
            diff      <= ovf_c ? sat_val_c : r_next_c;
            out_valid <= 1'b1;
`ifdef SUB_SAT_FLAG_EN
            sat       <= ovf_c;
`endif
            state     <= DONE;
          end
        end

        DONE: begin
          // Result held until the consumer takes it; one bubble back to IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef SUB_SAT_FLAG_EN
            sat       <= 1'b0;
`endif
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_signed_sub_sat.sv
// Directed self-checking bench for serial_signed_sub_sat (WIDTH = 4).
module tb_serial_signed_sub_sat;

  localparam int unsigned W = 4;
  localparam int MAXV = (1 <<< (W - 1)) - 1;
  localparam int MINV = -(1 <<< (W - 1));

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
`ifdef SUB_SAT_FLAG_EN
  logic         sat;
`endif

  int errors;
  int checks;
  int cyc;

  serial_signed_sub_sat #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff)
`ifdef SUB_SAT_FLAG_EN
    ,
    .sat       (sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: true signed difference clamped to the representable range.
  function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    if (d > MAXV) d = MAXV;
    else if (d < MINV) d = MINV;
    return W'(d);
  endfunction

  function automatic logic model_sat(input logic [W-1:0] x, input logic [W-1:0] y);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    return (d > MAXV) || (d < MINV);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation with latency and result checks, then drain.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp, input string name);
    int n;
    int edges;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    a = x; b = y; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin step(); edges++; end
    checks++;
    if (out_valid !== 1'b1 || edges != W + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (out_valid=%b), want %0d", name, edges, out_valid, W + 1);
    end
    checks++;
    if (diff !== exp) begin
      errors++;
      $display("FAIL %s diff: a=%b b=%b got %b want %b", name, x, y, diff, exp);
    end
`ifdef SUB_SAT_FLAG_EN
    checks++;
    if (sat !== model_sat(x, y)) begin
      errors++;
      $display("FAIL %s sat: got %b want %b", name, sat, model_sat(x, y));
    end
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b diff=%b want 1 0 0000", in_ready, out_valid, diff);
    end
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b diff=%b", in_ready, out_valid, diff);
    end
  endtask

  task automatic test_saturation();
    run_op(4'b0011, 4'b1010, 4'b0111, "pos_sat");
    run_op(4'b1011, 4'b0100, 4'b1000, "neg_sat");
    run_op(4'b0010, 4'b0101, 4'b1101, "plain_neg");
    run_op(4'b1111, 4'b0111, 4'b1000, "exact_min");
  endtask

  task automatic test_boundaries();
    run_op(4'b1000, 4'b1000, 4'b0000, "min_minus_min");
    run_op(4'b0000, 4'b1000, 4'b0111, "zero_minus_min");
    run_op(4'b1000, 4'b0001, 4'b1000, "min_minus_one");
    run_op(4'b0111, 4'b0111, 4'b0000, "max_minus_max");
  endtask

  task automatic test_backpressure();
    int n;
    a = 4'b0101; b = 4'b0010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    a = 4'b0001; b = 4'b0111; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || diff !== 4'b0011 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cyc%0d: out_valid=%b diff=%b in_ready=%b want 1 0011 0", i, out_valid, diff, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_single: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    a = 4'b0110; b = 4'b1001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run: out_valid=%b diff=%b in_ready=%b want 0 0000 1", out_valid, diff, in_ready);
    end
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: stray out_valid=%b in_ready=%b", seen, in_ready);
    end
    run_op(4'b0110, 4'b1001, 4'b0111, "after_reset");
    run_op(4'b0100, 4'b0001, 4'b0011, "after_reset2");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    int acc_prev;
    int n;
    va = '{4'b0001, 4'b1100, 4'b0111, 4'b1000};
    vb = '{4'b0011, 4'b0101, 4'b1111, 4'b1111};
    acc_prev = -1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i];
      n = 0;
      while (!in_ready && n < 20) begin step(); n++; end
      step();
      if (acc_prev >= 0) begin
        checks++;
        if (cyc - acc_prev != W + 2) begin
          errors++;
          $display("FAIL b2b_interval%0d: got %0d want %0d", i, cyc - acc_prev, W + 2);
        end
      end
      acc_prev = cyc;
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      checks++;
      if (out_valid !== 1'b1 || diff !== model_diff(va[i], vb[i])) begin
        errors++;
        $display("FAIL b2b_op%0d: out_valid=%b diff=%b want %b", i, out_valid, diff, model_diff(va[i], vb[i]));
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    step();
  endtask

  task automatic test_exhaustive();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(W'(i), W'(j), model_diff(W'(i), W'(j)), "sweep");
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    test_reset();
    test_saturation();
    test_boundaries();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
